// File: rtl/mem_stage_access.sv
// Memory-stage data-memory access controller: issues one valid/ready request per load/store and
// stalls the pipeline until the response. Optional WAIT abort is enabled by defining MEM_TIMEOUT_EN.
module mem_stage_access #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemMemRead,
  input  logic        MemMemWrite,
  input  logic [1:0]  MemXferSize,
  input  logic [63:0] MemAddr,
  input  logic [63:0] MemWriteData,
  output logic        DmemReqValid,
  input  logic        DmemReqReady,
  output logic        DmemReqWrite,
  output logic [63:0] DmemAddr,
  output logic [7:0]  DmemByteEn,
  output logic [63:0] DmemWData,
  input  logic        DmemRespValid,
  input  logic [63:0] DmemRData,
  output logic [63:0] MemOutput,
  output logic        MemStall,
  output logic        MemAccessErr
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [63:0] load_data_p1;
  logic        timeout_err_p1;
  logic        wait_timeout;

  logic        access;
  logic        is_store;
  logic        both_rw;
  logic        misaligned;
  logic [2:0]  lane;

  function automatic logic addr_misaligned(input logic [1:0] size, input logic [2:0] lo);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return lo[0];
      2'd2:    return |lo[1:0];
      default: return |lo;
    endcase
  endfunction

  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] ln);
    logic [7:0] m;
    case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << ln;
  endfunction

  function automatic logic [63:0] load_extract(input logic [63:0] rdata, input logic [1:0] size,
                                               input logic [2:0] ln);
    logic [63:0] s;
    s = rdata >> {ln, 3'b000};
    case (size)
      2'd0:    return {56'd0, s[7:0]};
      2'd1:    return {48'd0, s[15:0]};
      2'd2:    return {32'd0, s[31:0]};
      default: return s;
    endcase
  endfunction

  // A read/write collision is served as a load, so only a pure write is a store.
  assign access     = MemMemRead | MemMemWrite;
  assign both_rw    = MemMemRead & MemMemWrite;
  assign is_store   = MemMemWrite & ~MemMemRead;
  assign lane       = MemAddr[2:0];
  assign misaligned = addr_misaligned(MemXferSize, lane);
  assign DmemAddr   = {MemAddr[63:3], 3'b000};
  assign MemOutput  = load_data_p1;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Counter is held at zero outside WAIT, so it restarts on every entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state != WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign wait_timeout = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign wait_timeout = 1'b0;
`endif

  // Stage p0 -> p1: state, captured load result and timeout error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      load_data_p1   <= '0;
      timeout_err_p1 <= 1'b0;
    end else begin
      state          <= state_nxt;
      timeout_err_p1 <= (state == WAIT) && !DmemRespValid && wait_timeout;
      if ((state == IDLE) && access && misaligned) begin
        load_data_p1 <= '0;
      end else if ((state == WAIT) && DmemRespValid) begin
        if (MemMemRead) begin
          load_data_p1 <= load_extract(DmemRData, MemXferSize, lane);
        end
      end else if (wait_timeout) begin
        load_data_p1 <= '0;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    DmemReqValid = 1'b0;
    DmemReqWrite = 1'b0;
    DmemByteEn   = '0;
    DmemWData    = '0;
    MemStall     = 1'b0;
    MemAccessErr = timeout_err_p1;
    case (state)
      IDLE: begin
        if (access) begin
          if (misaligned || both_rw) begin
            MemAccessErr = 1'b1;
          end
          if (!misaligned) begin
            DmemReqValid = 1'b1;
            MemStall     = 1'b1;
            state_nxt    = DmemReqReady ? WAIT : REQ;
          end
        end
      end
      REQ: begin
        DmemReqValid = 1'b1;
        MemStall     = 1'b1;
        if (DmemReqReady) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        MemStall = 1'b1;
        if (DmemRespValid || wait_timeout) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Request payload is driven only alongside a valid request.
    if (DmemReqValid) begin
      DmemReqWrite = is_store;
      DmemByteEn   = lane_mask(MemXferSize, lane);
      if (is_store) begin
        DmemWData = MemWriteData << {lane, 3'b000};
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_access.sv
// Scoreboard bench for mem_stage_access: expected MemOutput values are queued when an access
// is driven and popped when the DUT reaches its completion cycle.
module tb_mem_stage_access;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemMemRead, MemMemWrite;
  logic [1:0]  MemXferSize;
  logic [63:0] MemAddr, MemWriteData;
  logic        DmemReqValid, DmemReqReady, DmemReqWrite;
  logic [63:0] DmemAddr, DmemWData, DmemRData, MemOutput;
  logic [7:0]  DmemByteEn;
  logic        DmemRespValid, MemStall, MemAccessErr;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] model_out = 64'd0;

  mem_stage_access #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .MemMemRead(MemMemRead), .MemMemWrite(MemMemWrite), .MemXferSize(MemXferSize),
    .MemAddr(MemAddr), .MemWriteData(MemWriteData),
    .DmemReqValid(DmemReqValid), .DmemReqReady(DmemReqReady), .DmemReqWrite(DmemReqWrite),
    .DmemAddr(DmemAddr), .DmemByteEn(DmemByteEn), .DmemWData(DmemWData),
    .DmemRespValid(DmemRespValid), .DmemRData(DmemRData),
    .MemOutput(MemOutput), .MemStall(MemStall), .MemAccessErr(MemAccessErr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] exp_extract(input logic [63:0] rd, input int size, input int ln);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < (1 << size); b++) r[8*b +: 8] = rd[8*(ln+b) +: 8];
    return r;
  endfunction

  function automatic logic [7:0] exp_mask(input int size, input int ln);
    logic [7:0] m;
    m = '0;
    for (int b = 0; b < (1 << size); b++) m[ln+b] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] exp_wdata(input logic [63:0] wd, input int ln);
    logic [63:0] w;
    w = '0;
    for (int b = 0; ln + b < 8; b++) w[8*(ln+b) +: 8] = wd[8*b +: 8];
    return w;
  endfunction

  task automatic idle_inputs;
    MemMemRead = 1'b0; MemMemWrite = 1'b0; MemXferSize = 2'd0;
    MemAddr = '0; MemWriteData = '0;
    DmemReqReady = 1'b0; DmemRespValid = 1'b0;
  endtask

  // Runs one access to completion; resp_dly < 0 means the memory never answers.
  task automatic run_access(input string name, input logic rd, input logic wr, input logic [1:0] sz,
                            input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] rdata,
                            input int rdy_dly, input int resp_dly, input logic stray,
                            input logic exp_err, input logic to_err, input logic [63:0] exp_out);
    int cyc, stalls, exp_stalls, resp_cyc;
    logic [7:0] ebe;
    logic [63:0] ewd, got;
    logic is_st;
    bit done;
    is_st = wr & ~rd;
    ebe = exp_mask(int'(sz), int'(addr[2:0]));
    ewd = is_st ? exp_wdata(wd, int'(addr[2:0])) : 64'd0;
    exp_stalls = (resp_dly < 0) ? rdy_dly + 1 + TO : rdy_dly + 2 + resp_dly;
    resp_cyc = (resp_dly < 0) ? -1 : rdy_dly + 1 + resp_dly;
    exp_q.push_back(exp_out);
    model_out = exp_out;
    MemMemRead = rd; MemMemWrite = wr; MemXferSize = sz; MemAddr = addr;
    MemWriteData = wd; DmemRData = rdata;
    cyc = 0; stalls = 0; done = 0;
    while (!done) begin
      DmemReqReady  = (cyc >= rdy_dly);
      DmemRespValid = (cyc == resp_cyc) || (stray && cyc <= rdy_dly);
      #1;
      checks++;
      if (cyc <= rdy_dly) begin
        if (DmemReqValid !== 1'b1 || DmemAddr !== {addr[63:3], 3'b000} || DmemByteEn !== ebe ||
            DmemWData !== ewd || DmemReqWrite !== is_st) begin
          failures++;
          $display("FAIL %s req cyc%0d: got v=%b a=%h be=%h wd=%h w=%b, want 1 %h %h %h %b", name, cyc,
                   DmemReqValid, DmemAddr, DmemByteEn, DmemWData, DmemReqWrite,
                   {addr[63:3], 3'b000}, ebe, ewd, is_st);
        end
      end else if (DmemReqValid !== 1'b0) begin
        failures++;
        $display("FAIL %s valid_after_accept cyc%0d: got %b want 0", name, cyc, DmemReqValid);
      end
      if (MemStall === 1'b1) begin
        stalls++;
        checks++;
        if (MemAccessErr !== ((cyc == 0) ? exp_err : 1'b0)) begin
          failures++;
          $display("FAIL %s err cyc%0d: got %b want %b", name, cyc, MemAccessErr,
                   (cyc == 0) ? exp_err : 1'b0);
        end
      end else begin
        done = 1;
        got = (exp_q.size() > 0) ? exp_q.pop_front() : 64'bx;
        checks++;
        if (stalls !== exp_stalls) begin
          failures++;
          $display("FAIL %s stall_cycles: got %0d want %0d", name, stalls, exp_stalls);
        end
        checks++;
        if (MemOutput !== got) begin
          failures++;
          $display("FAIL %s mem_output: got %h want %h", name, MemOutput, got);
        end
        checks++;
        if (MemAccessErr !== to_err) begin
          failures++;
          $display("FAIL %s done_err: got %b want %b", name, MemAccessErr, to_err);
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (!done && cyc > 300) begin
        failures++;
        $display("FAIL %s completion: got none after %0d cycles want done", name, cyc);
        done = 1;
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset;
    reset = 1'b0;
    idle_inputs();
    DmemRData = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (MemOutput !== 64'd0 || MemStall !== 1'b0 || DmemReqValid !== 1'b0 || MemAccessErr !== 1'b0 ||
        DmemByteEn !== 8'd0 || DmemWData !== 64'd0 || DmemReqWrite !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got out=%h st=%b v=%b err=%b be=%h wd=%h w=%b want all 0",
               MemOutput, MemStall, DmemReqValid, MemAccessErr, DmemByteEn, DmemWData, DmemReqWrite);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (MemStall !== 1'b0 || DmemReqValid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_release: got st=%b v=%b want 0 0", MemStall, DmemReqValid);
    end
  endtask

  task automatic test_loads;
    run_access("load_dword", 1, 0, 2'd3, 64'h1000, 64'd0, 64'h1122334455667788, 0, 2, 0, 0, 0,
               64'h1122334455667788);
    run_access("load_byte", 1, 0, 2'd0, 64'h1005, 64'd0, 64'h1122334455667788, 0, 0, 0, 0, 0,
               64'h0000000000000033);
  endtask

  task automatic test_store;
    run_access("store_half", 0, 1, 2'd1, 64'h2006, 64'hBEEF, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1, 1, 0, 0,
               model_out);
  endtask

  task automatic test_misaligned;
    logic [1:0]  sz_t [3] = '{2'd2, 2'd1, 2'd3};
    logic [63:0] ad_t [3] = '{64'h3002, 64'h3001, 64'h3004};
    logic        wr_t [3] = '{1'b0, 1'b1, 1'b0};
    logic [63:0] got;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(64'd0);
      model_out = 64'd0;
      MemMemRead = ~wr_t[i]; MemMemWrite = wr_t[i]; MemXferSize = sz_t[i]; MemAddr = ad_t[i];
      MemWriteData = 64'h1234; DmemReqReady = 1'b1;
      #1;
      checks++;
      if (DmemReqValid !== 1'b0 || MemStall !== 1'b0 || MemAccessErr !== 1'b1 || DmemByteEn !== 8'd0) begin
        failures++;
        $display("FAIL misaligned_%0d: got v=%b st=%b err=%b be=%h want 0 0 1 00", i,
                 DmemReqValid, MemStall, MemAccessErr, DmemByteEn);
      end
      @(posedge clk); #1;
      idle_inputs();
      #1;
      got = exp_q.pop_front();
      checks++;
      if (MemOutput !== got || MemAccessErr !== 1'b0 || MemStall !== 1'b0) begin
        failures++;
        $display("FAIL misaligned_after_%0d: got out=%h err=%b st=%b want %h 0 0", i,
                 MemOutput, MemAccessErr, MemStall, got);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_both_rw;
    run_access("both_rw", 1, 1, 2'd2, 64'h1004, 64'hFFFF_FFFF, 64'hAABBCCDD_11223344, 1, 0, 0, 1, 0,
               64'h00000000AABBCCDD);
  endtask

  task automatic test_reset_mid_wait;
    MemMemRead = 1'b1; MemXferSize = 2'd3; MemAddr = 64'h1000; DmemReqReady = 1'b1;
    DmemRData = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk); #1;
    DmemReqReady = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (MemOutput !== 64'd0 || MemStall !== 1'b0 || DmemReqValid !== 1'b0 || MemAccessErr !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_wait: got out=%h st=%b v=%b err=%b want 0 0 0 0",
               MemOutput, MemStall, DmemReqValid, MemAccessErr);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    DmemRespValid = 1'b1;
    @(posedge clk); #1;
    DmemRespValid = 1'b0;
    #1;
    checks++;
    if (MemOutput !== 64'd0 || MemStall !== 1'b0) begin
      failures++;
      $display("FAIL stale_response: got out=%h st=%b want 0 0", MemOutput, MemStall);
    end
    run_access("load_after_reset", 1, 0, 2'd1, 64'h1002, 64'd0, 64'h1122334455667788, 0, 1, 0, 0, 0,
               64'h0000000000005566);
  endtask

  task automatic test_back_to_back;
    int sz, ln, st;
    logic [63:0] rd, wd, eo;
    for (int i = 0; i < 8; i++) begin
      sz = $urandom_range(0, 3);
      ln = $urandom_range(0, 7) & ~((1 << sz) - 1);
      st = $urandom_range(0, 1);
      rd = {$urandom, $urandom};
      wd = {$urandom, $urandom};
      eo = st ? model_out : exp_extract(rd, sz, ln);
      run_access("b2b", ~st[0], st[0], sz[1:0], 64'h4000 + 64'(i * 8 + ln), wd, rd,
                 $urandom_range(0, 2), $urandom_range(0, 2), 0, 0, 0, eo);
    end
  endtask

  task automatic test_wait_limit;
    run_access("pre_wait_load", 1, 0, 2'd3, 64'h5000, 64'd0, 64'h0123456789ABCDEF, 0, 0, 0, 0, 0,
               64'h0123456789ABCDEF);
`ifdef MEM_TIMEOUT_EN
    run_access("timeout", 1, 0, 2'd3, 64'h5008, 64'd0, 64'hFFFF_0000_FFFF_0000, 0, -1, 0, 0, 1, 64'd0);
    DmemRespValid = 1'b1;
    @(posedge clk); #1;
    DmemRespValid = 1'b0;
    #1;
    checks++;
    if (MemOutput !== 64'd0 || MemAccessErr !== 1'b0 || MemStall !== 1'b0) begin
      failures++;
      $display("FAIL late_response: got out=%h err=%b st=%b want 0 0 0", MemOutput, MemAccessErr, MemStall);
    end
`else
    run_access("long_wait", 1, 0, 2'd2, 64'h5008, 64'd0, 64'h0000_0000_CAFE_F00D, 0, TO + 3, 0, 0, 0,
               64'h00000000CAFEF00D);
`endif
  endtask

  initial begin
    test_reset();
    test_loads();
    test_store();
    test_misaligned();
    test_both_rw();
    test_reset_mid_wait();
    test_back_to_back();
    test_wait_limit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
